// File: rtl/decode_mc_if.sv
// Bus between the instruction register / condition unit / FPU and the
// multicycle decoder-controller. The controller uses the slave modport.
interface decode_mc_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] Instr;
  logic            CondEx;
  logic            ExDone;
  logic            IRWrite;
  logic            AdrSrc;
  logic            NextPC;
  logic            RegW;
  logic            MemW;
  logic            WAsel;
  logic [1:0]      ResultSrc;
  logic [1:0]      ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ImmSrc;
  logic [1:0]      RegSrc;
  logic [1:0]      FlagW;
  logic [1:0]      FPUOp;
  logic [3:0]      ALUControl;
  logic            ExStart;
  logic            Busy;
  logic            Undef;
  logic [3:0]      State;

  modport master (
    output Instr, CondEx, ExDone,
    input  IRWrite, AdrSrc, NextPC, RegW, MemW, WAsel, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegSrc, FlagW, FPUOp, ALUControl, ExStart, Busy, Undef, State
  );

  modport slave (
    input  Instr, CondEx, ExDone,
    output IRWrite, AdrSrc, NextPC, RegW, MemW, WAsel, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegSrc, FlagW, FPUOp, ALUControl, ExStart, Busy, Undef, State
  );
endinterface

// File: rtl/decode_mc.sv
// Multicycle instruction decoder and main controller. Walks each instruction
// through fetch/decode/execute/writeback, with fixed-latency multiplies and a
// start/done handshake for FP ops. Define DECODE_MC_UNDEF_EN to trap on
// undefined mul-family and FP encodings.
module decode_mc #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned XLEN    = 32
) (
  input  logic        clk,
  input  logic        reset,
  decode_mc_if.slave  bus
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,  StDecode = 4'd1,  StExecR = 4'd2,  StExecI  = 4'd3,
    StMulW   = 4'd4,  StFpW    = 4'd5,  StAluWb = 4'd6,  StWbHi   = 4'd7,
    StMemAdr = 4'd8,  StMemRd  = 4'd9,  StMemWb = 4'd10, StMemWr  = 4'd11,
    StBranch = 4'd12, StTrap   = 4'd13
  } state_e;

  state_e     r_state, w_state_d;
  logic [3:0] r_cnt, w_cnt_d;
  logic       r_cx, w_cx_d;
  logic       r_fp_seen;

  // Instruction field decode; only the low 32 bits carry meaning.
  logic [31:0] w_instr;
  logic [1:0]  w_op;
  logic [5:0]  w_funct;
  logic        w_s, w_mul_fam, w_mul64, w_fp, w_cmp, w_rd_pc, w_trap;
  logic [3:0]  w_aluctl;
  logic [1:0]  w_flag;
  logic        w_unused_ok;

  assign w_instr     = bus.Instr[31:0];
  assign w_op        = w_instr[27:26];
  assign w_funct     = w_instr[25:20];
  assign w_s         = w_funct[0];
  assign w_rd_pc     = (w_instr[15:12] == 4'b1111);
  assign w_mul_fam   = (w_op == 2'b00) && (w_instr[7:4] == 4'b1001);
  assign w_mul64     = (w_funct[4:3] == 2'b01);
  assign w_fp        = (w_op == 2'b11);
  assign w_cmp       = w_s && ((w_funct[4:1] == 4'b1010) || (w_funct[4:1] == 4'b1000));
  assign w_unused_ok = ^{w_instr[31:28], w_instr[19:16], w_instr[11:8], w_instr[3:0]};

`ifdef DECODE_MC_UNDEF_EN
  assign w_trap = (w_mul_fam && (w_funct[4:1] != 4'b0000) && !w_mul64) ||
                  (w_fp && w_funct[5]);
`else
  // Undefined encodings fall through: odd multiplies run as mul32.
  assign w_trap = 1'b0;
`endif

  // ALU / multiplier operation from the instruction alone.
  always_comb begin
    w_aluctl = 4'b0000;
    if (w_mul_fam) begin
      w_aluctl = w_mul64 ? {2'b11, w_funct[2], w_s} : {3'b100, w_s};
    end else if (w_op == 2'b00) begin
      case (w_funct[4:1])
        4'b0010, 4'b1010: w_aluctl = 4'b0001;
        4'b0000, 4'b1000: w_aluctl = 4'b0010;
        4'b1100:          w_aluctl = 4'b0011;
        default:          w_aluctl = 4'b0000;
      endcase
    end
  end

  // Flag write value; squashed instructions never update flags.
  assign w_flag = {w_s, w_s && (w_aluctl[3:1] == 3'b000)} & {2{r_cx}};

  // State, counter and condition register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StFetch;
      r_cnt     <= 4'd0;
      r_cx      <= 1'b0;
      r_fp_seen <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_cx      <= w_cx_d;
      r_fp_seen <= (r_state == StFpW);
    end
  end

  // Next-state and datapath control outputs.
  always_comb begin
    w_state_d          = r_state;
    w_cnt_d            = r_cnt;
    w_cx_d             = r_cx;
    bus.IRWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.NextPC     = 1'b0;
    bus.RegW       = 1'b0;
    bus.MemW       = 1'b0;
    bus.WAsel      = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.FlagW      = 2'b00;
    bus.FPUOp      = 2'b00;
    bus.ExStart    = 1'b0;
    bus.Undef      = 1'b0;
    case (r_state)
      StFetch: begin
        bus.IRWrite   = 1'b1;
        bus.NextPC    = 1'b1;
        bus.ALUSrcA   = 2'b10;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        w_state_d     = StDecode;
      end
      StDecode: begin
        bus.ALUSrcA   = 2'b10;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        w_cx_d        = bus.CondEx;
        if (!bus.CondEx)            w_state_d = StFetch;
        else if (w_trap)            w_state_d = StTrap;
        else if (w_mul_fam) begin
          w_state_d = StMulW;
          w_cnt_d   = 4'(MUL_LAT - 1);
        end
        else if (w_fp)              w_state_d = StFpW;
        else if (w_op == 2'b01)     w_state_d = StMemAdr;
        else if (w_op == 2'b10)     w_state_d = StBranch;
        else if (w_funct[5])        w_state_d = StExecI;
        else                        w_state_d = StExecR;
      end
      StExecR, StExecI: begin
        bus.ALUSrcB = (r_state == StExecI) ? 2'b01 : 2'b00;
        bus.FlagW   = w_flag;
        w_state_d   = w_cmp ? StFetch : StAluWb;
      end
      StMulW: begin
        if (r_cnt == 4'd0) begin
          bus.FlagW = w_flag;
          w_state_d = w_mul64 ? StWbHi : StAluWb;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      StFpW: begin
        bus.FPUOp   = w_funct[2:1];
        bus.ExStart = !r_fp_seen;
        if (bus.ExDone) begin
          bus.FlagW = w_flag;
          w_state_d = StAluWb;
        end
      end
      StWbHi: begin
        bus.RegW  = 1'b1;
        bus.WAsel = 1'b1;
        w_state_d = StAluWb;
      end
      StAluWb: begin
        bus.RegW   = 1'b1;
        bus.NextPC = w_rd_pc;
        w_state_d  = StFetch;
      end
      StMemAdr: begin
        bus.ALUSrcB = 2'b01;
        w_state_d   = w_s ? StMemRd : StMemWr;
      end
      StMemRd: begin
        bus.AdrSrc = 1'b1;
        w_state_d  = StMemWb;
      end
      StMemWb: begin
        bus.RegW      = 1'b1;
        bus.ResultSrc = 2'b01;
        bus.NextPC    = w_rd_pc;
        w_state_d     = StFetch;
      end
      StMemWr: begin
        bus.MemW   = 1'b1;
        bus.AdrSrc = 1'b1;
        w_state_d  = StFetch;
      end
      StBranch: begin
        bus.NextPC    = 1'b1;
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        w_state_d     = StFetch;
      end
      StTrap: begin
        bus.Undef = 1'b1;
        w_state_d = StFetch;
      end
      default: w_state_d = StFetch;
    endcase
  end

  assign bus.ALUControl = w_aluctl;
  assign bus.ImmSrc     = w_op;
  assign bus.RegSrc     = {(w_op == 2'b01) && !w_s, (w_op == 2'b10)};
  assign bus.Busy       = (r_state != StFetch);
  assign bus.State      = r_state;

endmodule

// File: tb/tb_decode_mc.sv
// Directed bench for decode_mc: ADD, UMULLS, FP handshake, squash, store,
// reset during a multiply and the undefined-multiply encoding.
module tb_decode_mc;
  localparam int unsigned MulLat = 3;

  logic clk;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  decode_mc_if #(.XLEN(32)) bus ();

  decode_mc #(.MUL_LAT(MulLat), .XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset      = 1'b1;
    bus.Instr  = 32'h0;
    bus.CondEx = 1'b0;
    bus.ExDone = 1'b0;
    step();
    step();
    chk("rst_state", 32'(bus.State), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_regw", 32'(bus.RegW), 32'd0);
    chk("rst_memw", 32'(bus.MemW), 32'd0);
    chk("rst_exstart", 32'(bus.ExStart), 32'd0);

    // ADD r2, r1, r3
    reset      = 1'b0;
    bus.Instr  = 32'hE0812003;
    bus.CondEx = 1'b1;
    chk("add_fetch", 32'(bus.State), 32'd0);
    chk("add_irwrite", 32'(bus.IRWrite), 32'd1);
    step();
    chk("add_decode", 32'(bus.State), 32'd1);
    chk("add_busy", 32'(bus.Busy), 32'd1);
    chk("add_regw_c2", 32'(bus.RegW), 32'd0);
    step();
    chk("add_execr", 32'(bus.State), 32'd2);
    chk("add_aluctl", 32'(bus.ALUControl), 32'h0);
    chk("add_srcb", 32'(bus.ALUSrcB), 32'h0);
    chk("add_regw_c3", 32'(bus.RegW), 32'd0);
    chk("add_flagw", 32'(bus.FlagW), 32'h0);
    step();
    chk("add_aluwb", 32'(bus.State), 32'd6);
    chk("add_regw_c4", 32'(bus.RegW), 32'd1);
    chk("add_nextpc", 32'(bus.NextPC), 32'd0);
    step();
    chk("add_done", 32'(bus.State), 32'd0);

    // UMULLS
    bus.Instr = 32'hE0943291;
    step();
    chk("umull_decode", 32'(bus.State), 32'd1);
    for (int i = 0; i < int'(MulLat); i++) begin
      step();
      chk("umull_mulw", 32'(bus.State), 32'd4);
      chk("umull_aluctl", 32'(bus.ALUControl), 32'hD);
      chk("umull_flagw", 32'(bus.FlagW), (i == int'(MulLat) - 1) ? 32'h2 : 32'h0);
    end
    step();
    chk("umull_wbhi", 32'(bus.State), 32'd7);
    chk("umull_wasel_hi", 32'(bus.WAsel), 32'd1);
    chk("umull_regw_hi", 32'(bus.RegW), 32'd1);
    step();
    chk("umull_aluwb", 32'(bus.State), 32'd6);
    chk("umull_wasel_lo", 32'(bus.WAsel), 32'd0);
    chk("umull_regw_lo", 32'(bus.RegW), 32'd1);
    step();
    chk("umull_done", 32'(bus.State), 32'd0);

    // FP op, ExDone 5 cycles after ExStart; ExDone in FETCH must be ignored
    bus.Instr  = 32'hEC212003;
    bus.ExDone = 1'b1;
    step();
    bus.ExDone = 1'b0;
    chk("fp_decode", 32'(bus.State), 32'd1);
    step();
    chk("fp_fpw1", 32'(bus.State), 32'd5);
    chk("fp_exstart1", 32'(bus.ExStart), 32'd1);
    chk("fp_fpuop", 32'(bus.FPUOp), 32'h1);
    for (int c = 2; c <= 6; c++) begin
      step();
      chk("fp_fpw", 32'(bus.State), 32'd5);
      chk("fp_exstart_n", 32'(bus.ExStart), 32'd0);
      chk("fp_regw_n", 32'(bus.RegW), 32'd0);
      if (c == 6) bus.ExDone = 1'b1;
    end
    step();
    bus.ExDone = 1'b0;
    chk("fp_aluwb", 32'(bus.State), 32'd6);
    chk("fp_regw", 32'(bus.RegW), 32'd1);
    step();
    chk("fp_done", 32'(bus.State), 32'd0);

    // Squashed LDR
    bus.Instr  = 32'hE5912000;
    bus.CondEx = 1'b0;
    step();
    chk("sq_decode", 32'(bus.State), 32'd1);
    chk("sq_regw", 32'(bus.RegW), 32'd0);
    chk("sq_memw", 32'(bus.MemW), 32'd0);
    chk("sq_flagw", 32'(bus.FlagW), 32'h0);
    step();
    chk("sq_fetch", 32'(bus.State), 32'd0);

    // STR
    bus.Instr  = 32'hE5812000;
    bus.CondEx = 1'b1;
    step();
    chk("str_memw_c2", 32'(bus.MemW), 32'd0);
    step();
    chk("str_memadr", 32'(bus.State), 32'd8);
    chk("str_srcb", 32'(bus.ALUSrcB), 32'h1);
    chk("str_regsrc", 32'(bus.RegSrc), 32'h2);
    step();
    chk("str_memwr", 32'(bus.State), 32'd11);
    chk("str_memw", 32'(bus.MemW), 32'd1);
    chk("str_adrsrc", 32'(bus.AdrSrc), 32'd1);
    step();
    chk("str_done", 32'(bus.State), 32'd0);
    chk("str_memw_after", 32'(bus.MemW), 32'd0);

    // Reset in the 2nd MULW cycle, then a full multiply
    bus.Instr = 32'hE0943291;
    step();
    step();
    chk("rmul_mulw1", 32'(bus.State), 32'd4);
    step();
    chk("rmul_mulw2", 32'(bus.State), 32'd4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rmul_fetch", 32'(bus.State), 32'd0);
    chk("rmul_regw", 32'(bus.RegW), 32'd0);
    step();
    chk("rmul_decode", 32'(bus.State), 32'd1);
    for (int i = 0; i < int'(MulLat); i++) begin
      step();
      chk("rmul_mulw", 32'(bus.State), 32'd4);
    end
    step();
    chk("rmul_wbhi", 32'(bus.State), 32'd7);
    step();
    step();
    chk("rmul_done", 32'(bus.State), 32'd0);

    // Undefined mul encoding: Funct[4:1]=0011, S=1
    bus.Instr = 32'hE0743291;
    step();
    step();
`ifdef DECODE_MC_UNDEF_EN
    chk("undef_trap", 32'(bus.State), 32'd13);
    chk("undef_flag", 32'(bus.Undef), 32'd1);
    step();
    chk("undef_done", 32'(bus.State), 32'd0);
    chk("undef_clear", 32'(bus.Undef), 32'd0);
`else
    for (int i = 0; i < int'(MulLat); i++) begin
      chk("undef_mulw", 32'(bus.State), 32'd4);
      chk("undef_aluctl", 32'(bus.ALUControl), 32'h9);
      chk("undef_nundef", 32'(bus.Undef), 32'd0);
      step();
    end
    chk("undef_aluwb", 32'(bus.State), 32'd6);
    step();
    chk("undef_done", 32'(bus.State), 32'd0);
`endif

    // ADD to PC asserts NextPC in writeback
    bus.Instr = 32'hE081F003;
    step();
    step();
    step();
    chk("pc_aluwb", 32'(bus.State), 32'd6);
    chk("pc_nextpc", 32'(bus.NextPC), 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
